// File: rtl/bit8_adder.sv
// Registered 8-bit unsigned adder: a ripple-carry chain of eight full-adder
// cells feeding a one-cycle output register with a valid strobe.

module bit8_full_adder (
  input  logic p,
  input  logic q,
  input  logic cin,
  output logic r,
  output logic cout
);
  assign r    = p ^ q ^ cin;
  assign cout = (p & q) | ((p ^ q) & cin);
endmodule

module bit8_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       in_valid,
  output logic [7:0] sum,
  output logic       cout,
  output logic       out_valid
);
  logic [8:0] carry;
  logic [7:0] core_sum;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_stage
      bit8_full_adder u_fa (
        .p    (a[gi]),
        .q    (b[gi]),
        .cin  (carry[gi]),
        .r    (core_sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Result registers only load on accepted operands, so idle-cycle inputs
  // (including X/Z) never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 8'h00;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= core_sum;
        cout <= carry[8];
      end
    end
  end
endmodule

// File: tb/tb_bit8_adder.sv
// Scoreboard bench for bit8_adder: drivers push expected {cout,sum} on valid
// input, a posedge monitor pops and checks results, idle hold and latency.

module tb_bit8_adder;
  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;

  int tests_run = 0;
  int fails     = 0;
  logic [8:0] exp_q[$];
  logic [8:0] hold_val = 9'h000;

  bit8_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer side of the scoreboard; prints only the first few failures.
  always @(posedge clk) begin
    logic       v;
    logic [8:0] e;
    v = in_valid && rst_n;
    if (!rst_n) hold_val = 9'h000;
    #1;
    tests_run++;
    if (out_valid !== v) begin
      fails++;
      if (fails < 20) $display("FAIL mon_valid: got %b want %b at %0t", out_valid, v, $time);
    end
    if (v) begin
      if (exp_q.size() == 0) begin
        e = 9'h1xx;
        tests_run++;
        fails++;
        if (fails < 20) $display("FAIL mon_underflow: result with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        hold_val = e;
        tests_run++;
        if ({cout, sum} !== e) begin
          fails++;
          if (fails < 20) $display("FAIL mon_result: got %h want %h at %0t", {cout, sum}, e, $time);
        end
      end
    end else begin
      tests_run++;
      if ({cout, sum} !== hold_val) begin
        fails++;
        if (fails < 20) $display("FAIL mon_hold: got %h want %h at %0t", {cout, sum}, hold_val, $time);
      end
    end
  end

  task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic dv);
    @(negedge clk);
    a        = da;
    b        = db;
    in_valid = dv;
    if (dv) exp_q.push_back({1'b0, da} + {1'b0, db});
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    in_valid = 1'b0;
    #3;
    tests_run++;
    if ({out_valid, cout, sum} !== 10'h000) begin
      fails++;
      $display("FAIL reset_init: got %h want 000", {out_valid, cout, sum});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_basic;
    drive(8'h01, 8'h03, 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    $display("[TB] basic 01+03");
  endtask

  task automatic test_carry;
    drive(8'h7F, 8'h01, 1'b1);
    drive(8'h80, 8'h80, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1);
    drive(8'hFF, 8'h01, 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    $display("[TB] carry boundaries 7F+01 80+80 FF+FF FF+01");
  endtask

  task automatic test_back_to_back;
    drive(8'h10, 8'h20, 1'b1);
    drive(8'hF0, 8'h20, 1'b1);
    drive(8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    $display("[TB] back-to-back 10+20 F0+20 00+00");
  endtask

  task automatic test_hold;
    drive(8'h01, 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(8'hA5 + 8'(i * 17), 8'h5A - 8'(i * 3), 1'b0);
      #1;
      if (i > 0) begin
        tests_run++;
        if ({out_valid, cout, sum} !== 10'h004) begin
          fails++;
          $display("FAIL hold_%0d: got %h want 004", i, {out_valid, cout, sum});
        end
      end
    end
    $display("[TB] hold 04/0 over idle cycles");
  endtask

  task automatic test_reset_midcycle;
    drive(8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    #3;
    tests_run++;
    if ({out_valid, cout, sum} !== 10'h3FE) begin
      fails++;
      $display("FAIL pre_reset: got %h want 3fe", {out_valid, cout, sum});
    end
    // New operand offered while reset is held must be ignored.
    a        = 8'h11;
    b        = 8'h22;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, cout, sum} !== 10'h000) begin
      fails++;
      $display("FAIL reset_async: got %h want 000", {out_valid, cout, sum});
    end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    #1;
    tests_run++;
    if ({out_valid, cout, sum} !== 10'h000) begin
      fails++;
      $display("FAIL reset_discard: got %h want 000", {out_valid, cout, sum});
    end
    $display("[TB] mid-cycle reset with pending result");
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        drive(8'(i), 8'(j), 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 1'b0);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL exhaustive_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] exhaustive 65536 pairs");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_hold();
    test_reset_midcycle();
    test_exhaustive();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
